// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - multi-product vending controller with price table, stock and refund
module vend_ctrl_multi #(
    parameter int MONEY_W    = 7,
    parameter int N_PROD     = 4,
    parameter int PROD_W     = 3,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 2,
    parameter logic [N_PROD*MONEY_W-1:0] PRICE_LIST = {7'd25, 7'd20, 7'd15, 7'd10}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] money,
    input  logic               sel_valid,
    input  logic [PROD_W-1:0]  prod,
    input  logic               cancel,
    input  logic               restock,
    output logic [MONEY_W-1:0] credit,
    output logic               busy,
    output logic               sold,
    output logic [PROD_W-1:0]  sold_prod,
    output logic               change_valid,
    output logic [MONEY_W-1:0] rem,
    output logic               coin_reject,
    output logic               deny_funds,
    output logic               out_of_stock,
    output logic               bad_sel
);

    typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE, S_REFUND} state_t;

    state_t               r_state, w_state_nx;
    logic [MONEY_W-1:0]   r_credit, w_credit_nx;
    logic [MONEY_W-1:0]   r_rem, w_rem_nx;
    logic [PROD_W-1:0]    r_sold_prod, w_sold_prod_nx;
    logic [PROD_W-1:0]    r_prod, w_prod_nx;
    logic                 r_sold, w_sold_nx;
    logic                 r_change_valid, w_change_valid_nx;
    logic                 r_coin_reject, w_coin_reject_nx;
    logic                 r_deny_funds, w_deny_funds_nx;
    logic                 r_out_of_stock, w_out_of_stock_nx;
    logic                 r_bad_sel, w_bad_sel_nx;
    logic [STOCK_W-1:0]   r_stock [N_PROD];
    logic [STOCK_W-1:0]   w_stock_nx [N_PROD];

    logic [MONEY_W:0]     w_sum;
    logic                 w_sel_bad;
    logic [MONEY_W-1:0]   w_sel_price;
    logic [STOCK_W-1:0]   w_sel_stock;
    logic [MONEY_W-1:0]   w_vend_price;

    // Price/stock lookup for the incoming selection and the latched product
    always_comb begin
        w_sum        = {1'b0, r_credit} + {1'b0, money};
        w_sel_bad    = (prod == '0) || (prod > PROD_W'(N_PROD));
        w_sel_price  = '0;
        w_sel_stock  = '0;
        w_vend_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (prod == PROD_W'(i + 1)) begin
                w_sel_price = PRICE_LIST[i*MONEY_W +: MONEY_W];
                w_sel_stock = r_stock[i];
            end
            if (r_prod == PROD_W'(i + 1)) begin
                w_vend_price = PRICE_LIST[i*MONEY_W +: MONEY_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state_nx        = r_state;
        w_credit_nx       = r_credit;
        w_rem_nx          = r_rem;
        w_sold_prod_nx    = r_sold_prod;
        w_prod_nx         = r_prod;
        w_sold_nx         = 1'b0;
        w_change_valid_nx = 1'b0;
        w_coin_reject_nx  = 1'b0;
        w_deny_funds_nx   = 1'b0;
        w_out_of_stock_nx = 1'b0;
        w_bad_sel_nx      = 1'b0;
        w_stock_nx        = r_stock;
        case (r_state)
            S_IDLE: begin
                if (restock) begin
                    for (int i = 0; i < N_PROD; i++) w_stock_nx[i] = STOCK_W'(INIT_STOCK);
                end
                if (cancel) begin
                    w_state_nx       = S_REFUND;
                    w_coin_reject_nx = coin_valid;
                end else if (sel_valid) begin
                    // a coin alongside a selection is never credited
                    w_coin_reject_nx = coin_valid;
                    if (w_sel_bad)                  w_bad_sel_nx      = 1'b1;
                    else if (w_sel_stock == '0)     w_out_of_stock_nx = 1'b1;
                    else if (r_credit < w_sel_price) w_deny_funds_nx  = 1'b1;
                    else begin
                        w_prod_nx  = prod;
                        w_state_nx = S_VEND;
                    end
                end else if (coin_valid) begin
                    if (w_sum[MONEY_W]) w_coin_reject_nx = 1'b1;
                    else                w_credit_nx      = w_sum[MONEY_W-1:0];
                end
            end
            S_VEND: begin
                w_sold_nx        = 1'b1;
                w_sold_prod_nx   = r_prod;
                w_credit_nx      = r_credit - w_vend_price;
                w_coin_reject_nx = coin_valid;
                w_state_nx       = S_CHANGE;
                for (int i = 0; i < N_PROD; i++) begin
                    if (r_prod == PROD_W'(i + 1)) w_stock_nx[i] = r_stock[i] - STOCK_W'(1);
                end
            end
            S_CHANGE, S_REFUND: begin
                w_change_valid_nx = 1'b1;
                w_rem_nx          = r_credit;
                w_credit_nx       = '0;
                w_coin_reject_nx  = coin_valid;
                w_state_nx        = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_rem          <= '0;
            r_sold_prod    <= '0;
            r_prod         <= '0;
            r_sold         <= 1'b0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_deny_funds   <= 1'b0;
            r_out_of_stock <= 1'b0;
            r_bad_sel      <= 1'b0;
            for (int i = 0; i < N_PROD; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            r_state        <= w_state_nx;
            r_credit       <= w_credit_nx;
            r_rem          <= w_rem_nx;
            r_sold_prod    <= w_sold_prod_nx;
            r_prod         <= w_prod_nx;
            r_sold         <= w_sold_nx;
            r_change_valid <= w_change_valid_nx;
            r_coin_reject  <= w_coin_reject_nx;
            r_deny_funds   <= w_deny_funds_nx;
            r_out_of_stock <= w_out_of_stock_nx;
            r_bad_sel      <= w_bad_sel_nx;
            r_stock        <= w_stock_nx;
        end
    end

    assign credit       = r_credit;
    assign busy         = (r_state != S_IDLE);
    assign sold         = r_sold;
    assign sold_prod    = r_sold_prod;
    assign change_valid = r_change_valid;
    assign rem          = r_rem;
    assign coin_reject  = r_coin_reject;
    assign deny_funds   = r_deny_funds;
    assign out_of_stock = r_out_of_stock;
    assign bad_sel      = r_bad_sel;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - directed-vector bench with a transaction-level vending model
module tb_vend_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [6:0] money = '0;
    logic       sel_valid = 1'b0;
    logic [2:0] prod = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [6:0] credit;
    logic       busy;
    logic       sold;
    logic [2:0] sold_prod;
    logic       change_valid;
    logic [6:0] rem;
    logic       coin_reject;
    logic       deny_funds;
    logic       out_of_stock;
    logic       bad_sel;

    vend_ctrl_multi dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .money(money),
        .sel_valid(sel_valid), .prod(prod), .cancel(cancel), .restock(restock),
        .credit(credit), .busy(busy), .sold(sold), .sold_prod(sold_prod),
        .change_valid(change_valid), .rem(rem), .coin_reject(coin_reject),
        .deny_funds(deny_funds), .out_of_stock(out_of_stock), .bad_sel(bad_sel)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state: money held, sale waiting to dispense, change/refund waiting to pay out
    int m_credit, m_rem, m_sold_prod, m_pend_sale;
    bit m_pend_chg;
    int m_stock [1:4];
    bit e_sold, e_cv, e_cr, e_df, e_oos, e_bad;

    function automatic int price(input int p);
        return 5 + 5 * p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit cv, input int m, input bit sv,
                              input int p, input bit can, input bit rs);
        e_sold = 0; e_cv = 0; e_cr = 0; e_df = 0; e_oos = 0; e_bad = 0;
        if (r) begin
            m_credit = 0; m_rem = 0; m_sold_prod = 0; m_pend_sale = 0; m_pend_chg = 0;
            for (int i = 1; i <= 4; i++) m_stock[i] = 2;
        end else if (m_pend_sale != 0) begin
            e_sold      = 1;
            m_sold_prod = m_pend_sale;
            m_stock[m_pend_sale]--;
            m_credit   -= price(m_pend_sale);
            m_pend_sale = 0;
            m_pend_chg  = 1;
            e_cr        = cv;
        end else if (m_pend_chg) begin
            e_cv       = 1;
            m_rem      = m_credit;
            m_credit   = 0;
            m_pend_chg = 0;
            e_cr       = cv;
        end else begin
            if (can) begin
                m_pend_chg = 1;
                e_cr       = cv;
            end else if (sv) begin
                e_cr = cv;
                if (p < 1 || p > 4)              e_bad = 1;
                else if (m_stock[p] == 0)        e_oos = 1;
                else if (m_credit < price(p))    e_df  = 1;
                else                             m_pend_sale = p;
            end else if (cv) begin
                if (m_credit + m > 127) e_cr = 1;
                else                    m_credit += m;
            end
            if (rs) for (int i = 1; i <= 4; i++) m_stock[i] = 2;
        end
    endtask

    // apply one vector, advance one clock, compare every output against the model
    task automatic cyc(input bit r, input bit cv, input int m, input bit sv,
                       input int p, input bit can, input bit rs);
        rst = r; coin_valid = cv; money = 7'(m); sel_valid = sv; prod = 3'(p);
        cancel = can; restock = rs;
        @(posedge clk);
        model_step(r, cv, m, sv, p, can, rs);
        #1;
        check("credit", 32'(credit), 32'(m_credit));
        check("busy", 32'(busy), 32'((m_pend_sale != 0) || m_pend_chg));
        check("sold", 32'(sold), 32'(e_sold));
        check("sold_prod", 32'(sold_prod), 32'(m_sold_prod));
        check("change_valid", 32'(change_valid), 32'(e_cv));
        check("rem", 32'(rem), 32'(m_rem));
        check("coin_reject", 32'(coin_reject), 32'(e_cr));
        check("deny_funds", 32'(deny_funds), 32'(e_df));
        check("out_of_stock", 32'(out_of_stock), 32'(e_oos));
        check("bad_sel", 32'(bad_sel), 32'(e_bad));
    endtask

    task automatic do_rst();            cyc(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_idle();           cyc(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_coin(input int m); cyc(0, 1, m, 0, 0, 0, 0); endtask
    task automatic do_sel(input int p);  cyc(0, 0, 0, 1, p, 0, 0); endtask
    task automatic do_cancel();         cyc(0, 0, 0, 0, 0, 1, 0); endtask

    initial begin
        // reset state and simple purchase, exact change
        do_rst();
        check("pin_reset_credit", 32'(credit), 0);
        check("pin_reset_busy", 32'(busy), 0);
        do_coin(10);
        do_sel(1);
        do_idle();
        check("pin_t1_sold", 32'(sold), 1);
        check("pin_t1_sold_prod", 32'(sold_prod), 1);
        do_idle();
        check("pin_t1_change", 32'(change_valid), 1);
        check("pin_t1_rem", 32'(rem), 0);

        // two coins, price 15, coin rejected during VEND
        do_rst();
        do_coin(5);
        do_coin(15);
        check("pin_t2_credit", 32'(credit), 20);
        do_sel(2);
        cyc(0, 1, 3, 0, 0, 0, 0);
        check("pin_t2_reject", 32'(coin_reject), 1);
        check("pin_t2_credit_vend", 32'(credit), 5);
        do_idle();
        check("pin_t2_rem", 32'(rem), 5);
        do_idle();
        check("pin_rem_held", 32'(rem), 5);

        // insufficient funds repeated, then refund
        do_coin(10);
        do_sel(3);
        check("pin_t3_deny", 32'(deny_funds), 1);
        do_sel(3);
        check("pin_t3_deny_again", 32'(deny_funds), 1);
        do_cancel();
        do_idle();
        check("pin_t3_refund", 32'(rem), 10);
        check("pin_t3_credit", 32'(credit), 0);

        // stock exhaustion and restock
        do_rst();
        for (int k = 0; k < 2; k++) begin
            do_coin(10); do_sel(1); do_idle(); do_idle();
        end
        do_coin(10);
        do_sel(1);
        check("pin_t4_oos", 32'(out_of_stock), 1);
        check("pin_t4_credit", 32'(credit), 10);
        cyc(0, 0, 0, 0, 0, 0, 1);
        do_sel(1);
        do_idle();
        check("pin_t4_sold", 32'(sold), 1);
        do_idle();

        // saturation and bad codes; coin with cancel
        do_coin(120);
        do_coin(10);
        check("pin_t5_reject", 32'(coin_reject), 1);
        do_coin(7);
        check("pin_t5_max", 32'(credit), 127);
        do_sel(0);
        check("pin_t5_bad0", 32'(bad_sel), 1);
        do_sel(5);
        check("pin_t5_bad5", 32'(bad_sel), 1);
        do_sel(7);
        cyc(0, 1, 4, 0, 0, 1, 0);
        check("pin_cancel_coin", 32'(coin_reject), 1);
        do_idle();
        check("pin_t5_rem", 32'(rem), 127);

        // reset in the VEND cycle discards the sale
        do_coin(25);
        do_sel(4);
        do_rst();
        check("pin_t6_nosold", 32'(sold), 0);
        check("pin_t6_credit", 32'(credit), 0);
        check("pin_t6_busy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            do_coin(25); do_sel(4); do_idle(); do_idle();
        end
        do_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised multi-product vending controller: the next generation of the single-price vending block.
- Accumulates coin credit, checks the selection against a per-product price table and stock counters, then issues a one-cycle dispense pulse followed by change.
- Adds features the earlier block lacks: a cancel/refund path, credit saturation, stock tracking with restock, and error pulses.
- Sits between the coin/keypad front end and the dispenser/coin-return actuators.

Parameters:
- MONEY_W, 7: width of coin, credit and change values; max credit is 2^MONEY_W-1.
- N_PROD, 4: number of products; product codes are 1..N_PROD, and code 0 means no selection.
- PROD_W, 3: width of the product code; must satisfy 2^PROD_W > N_PROD.
- STOCK_W, 4: width of each stock counter.
- INIT_STOCK, 2: stock loaded into every product on reset and on restock.
- PRICE_LIST, {7'd25,7'd20,7'd15,7'd10}: packed N_PROD*MONEY_W vector; price of code i is at bits [(i-1)*MONEY_W +: MONEY_W].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  coin present this cycle.
- money  in  MONEY_W  coin value, qualified by coin_valid.
- sel_valid  in  1  selection strobe.
- prod  in  PROD_W  selected product code.
- cancel  in  1  refund request.
- restock  in  1  reload all stock counters to INIT_STOCK.
- credit  out  MONEY_W  current credit.
- busy  out  1  high when state is not IDLE.
- sold  out  1  one-cycle dispense pulse.
- sold_prod  out  PROD_W  product dispensed; valid with sold.
- change_valid  out  1  one-cycle change/refund pulse.
- rem  out  MONEY_W  change amount; updated with change_valid and held afterwards.
- coin_reject  out  1  one-cycle pulse: coin refused.
- deny_funds  out  1  one-cycle pulse: credit is below price.
- out_of_stock  out  1  one-cycle pulse: selected product has stock 0.
- bad_sel  out  1  one-cycle pulse: prod is 0 or greater than N_PROD.

Behaviour:
- All outputs are registered.
- Reset values:
  - credit, rem and sold_prod are 0.
  - All pulse outputs are 0.
  - state is IDLE.
  - Every stock counter is INIT_STOCK.
  - rst overrides all other inputs, including mid-VEND or mid-CHANGE; a pending sale is discarded with no sold pulse.
- State IDLE, input priority per cycle is cancel > sel_valid > coin_valid.
  - cancel: go to REFUND. A coin arriving in the same cycle gets coin_reject.
  - sel_valid with a bad code: bad_sel pulse, stay in IDLE.
  - sel_valid with stock[prod]==0: out_of_stock pulse, stay in IDLE, credit kept.
  - sel_valid with credit < price: deny_funds pulse, stay in IDLE, credit kept.
  - Otherwise: latch prod, go to VEND. A coin in the same cycle gets coin_reject.
  - coin_valid alone: credit += money if the sum is ≤ 2^MONEY_W-1. On overflow, coin_reject pulse and credit unchanged. Sum width is MONEY_W+1.
  - restock is honoured in IDLE only; restock together with a sale acceptance is performed.
- State VEND, one cycle:
  - sold=1 and sold_prod=latched code.
  - stock[latched] decrements.
  - credit -= price; this never underflows.
  - Go to CHANGE.
- States CHANGE and REFUND, one cycle:
  - change_valid=1 and rem=credit, even when credit is 0.
  - credit=0.
  - Go to IDLE.
- Outside IDLE:
  - Any coin_valid produces a coin_reject pulse.
  - sel_valid, cancel and restock are ignored.
- Latency:
  - An accepted selection sampled at edge T gives sold high after edge T+1, and change_valid and rem after edge T+2.
  - A cancel sampled at edge T gives change_valid after edge T+1.
- Error pulses last exactly one cycle and can repeat every cycle.

Test Plan:
- rst; coin 10; sel prod=1 → sold=1 and sold_prod=1 one cycle later; next cycle change_valid=1, rem=0, credit=0; stock1=1.
- rst; coins 5 then 15; sel prod=2 (price 15) → sold, sold_prod=2, rem=5; coin during VEND gives coin_reject with credit unchanged.
- credit 10; sel prod=3 (price 20) → deny_funds pulse, credit stays 10; then cancel → change_valid, rem=10, credit=0, no sold.
- Buy prod 1 twice at 10 each; third attempt with credit 10 → out_of_stock, credit 10 kept; restock, then select → sold.
- Credit 120; coin 10 → coin_reject, credit 120; coin 7 → credit 127; sel prod=0 and prod=5 → bad_sel each.
- Credit 25; sel prod=4; assert rst in the VEND cycle → no sold, credit 0, all stocks=2, state IDLE.
